// File: rtl/serial_addsub_unit.sv
// rtl/serial_addsub_unit.sv - chunk-serial adder/subtractor with registered result and flags
// Processes CHUNK bits per cycle; result and flags load only on the last chunk.

module serial_addsub_unit #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_sum_next;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [CHUNK:0]   w_chunk;
  logic             w_cin_msb;

  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        if (r_cnt == LAST) w_next = DONE;
      end
      DONE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // One chunk of the ripple add; b was pre-inverted and carry seeded with sub on accept.
  always_comb begin
    w_chunk = {1'b0, r_op_a[r_cnt*CHUNK +: CHUNK]}
            + {1'b0, r_op_b[r_cnt*CHUNK +: CHUNK]}
            + {{CHUNK{1'b0}}, r_carry};
    w_sum_next = r_sum;
    w_sum_next[r_cnt*CHUNK +: CHUNK] = w_chunk[CHUNK-1:0];
    w_last    = (r_state == RUN) && (r_cnt == LAST);
    w_cin_msb = r_op_a[WIDTH-1] ^ r_op_b[WIDTH-1] ^ w_sum_next[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_op_a  <= a;
      r_op_b  <= b ^ {WIDTH{sub}};
      r_carry <= sub;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_sum   <= w_sum_next;
      r_carry <= w_chunk[CHUNK];
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
    end else if (w_last) begin
      r_result <= w_sum_next;
      r_cout   <= w_chunk[CHUNK];
      r_ovf    <= w_cin_msb ^ w_chunk[CHUNK];
      r_zero   <= (w_sum_next == '0);
      r_neg    <= w_sum_next[WIDTH-1];
    end
  end

  assign busy   = (r_state == RUN);
  assign done   = (r_state == DONE);
  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;
  assign zero   = r_zero;
  assign neg    = r_neg;

endmodule

// File: tb/tb_serial_addsub_unit.sv
// tb/tb_serial_addsub_unit.sv - directed-vector bench for serial_addsub_unit
// Two instances: WIDTH=8/CHUNK=2 and WIDTH=16/CHUNK=16.

module tb_serial_addsub_unit;

  logic clk;
  logic rst_n;

  logic        start8, sub8, busy8, done8, cout8, ovf8, zero8, neg8;
  logic [7:0]  a8, b8, res8;
  logic        start16, sub16, busy16, done16, cout16, ovf16, zero16, neg16;
  logic [15:0] a16, b16, res16;

  int n_cmp;
  int n_err;

  serial_addsub_unit #(.WIDTH(8), .CHUNK(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .cout(cout8), .ovf(ovf8),
    .zero(zero8), .neg(neg8)
  );

  serial_addsub_unit #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(res16), .cout(cout16), .ovf(ovf16),
    .zero(zero16), .neg(neg16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input bit sel, input string tag, input logic [15:0] r,
                           input logic c, input logic o, input logic z, input logic ng);
    chk({tag, ".result"}, sel ? 32'(res16)  : 32'(res8),  32'(r));
    chk({tag, ".cout"},   sel ? 32'(cout16) : 32'(cout8), 32'(c));
    chk({tag, ".ovf"},    sel ? 32'(ovf16)  : 32'(ovf8),  32'(o));
    chk({tag, ".zero"},   sel ? 32'(zero16) : 32'(zero8), 32'(z));
    chk({tag, ".neg"},    sel ? 32'(neg16)  : 32'(neg8),  32'(ng));
  endtask

  task automatic launch(input bit sel, input logic [15:0] av, input logic [15:0] bv, input logic sv);
    if (sel) begin
      start16 = 1'b1; a16 = av; b16 = bv; sub16 = sv;
    end else begin
      start8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; sub8 = sv;
    end
    @(posedge clk);
    #1;
    start8  = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input string tag, output int nbusy, output int dat);
    logic bz, dn;
    nbusy = 0;
    dat   = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bz = sel ? busy16 : busy8;
      dn = sel ? done16 : done8;
      if (bz && dn) chk({tag, ".busy_and_done"}, 32'd1, 32'd0);
      if (bz) nbusy++;
      if (dn) begin
        dat = k;
        break;
      end
    end
    if (dat == 0) chk({tag, ".done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_op(input bit sel, input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic sv, input int exp_busy, input int exp_done, input logic [15:0] r,
                       input logic c, input logic o, input logic z, input logic ng);
    int nb, da;
    @(negedge clk);
    launch(sel, av, bv, sv);
    wait_done(sel, tag, nb, da);
    chk({tag, ".busy_cycles"}, 32'(nb), 32'(exp_busy));
    chk({tag, ".done_cycle"},  32'(da), 32'(exp_done));
    check_res(sel, tag, r, c, o, z, ng);
  endtask

  initial begin
    int nb, da;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.busy8", 32'(busy8), 32'd0);
    chk("rst.done8", 32'(done8), 32'd0);
    check_res(1'b0, "rst8", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.busy16", 32'(busy16), 32'd0);
    check_res(1'b1, "rst16", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    do_op(1'b0, "add_7f_01", 16'h7F, 16'h01, 1'b0, 4, 5, 16'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    do_op(1'b0, "sub_05_05", 16'h05, 16'h05, 1'b1, 4, 5, 16'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op(1'b0, "sub_80_01", 16'h80, 16'h01, 1'b1, 4, 5, 16'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
    do_op(1'b0, "sub_03_05", 16'h03, 16'h05, 1'b1, 4, 5, 16'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op(1'b0, "add_ff_01", 16'hFF, 16'h01, 1'b0, 4, 5, 16'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op(1'b0, "sub_7f_ff", 16'h7F, 16'hFF, 1'b1, 4, 5, 16'h80, 1'b0, 1'b1, 1'b0, 1'b1);

    // start with junk operands during RUN must not disturb the operation
    @(negedge clk);
    launch(1'b0, 16'h12, 16'h34, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("ign.busy_c2", 32'(busy8), 32'd1);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    wait_done(1'b0, "ign", nb, da);
    chk("ign.busy_cycles", 32'(nb), 32'd2);
    chk("ign.done_cycle", 32'(da), 32'd3);
    check_res(1'b0, "ign", 16'h46, 1'b0, 1'b0, 1'b0, 1'b0);

    // start held in DONE: straight back into RUN, old result held meanwhile
    launch(1'b0, 16'h10, 16'h01, 1'b1);
    @(negedge clk);
    chk("b2b.busy_first", 32'(busy8), 32'd1);
    chk("b2b.done_first", 32'(done8), 32'd0);
    chk("b2b.result_hold", 32'(res8), 32'h46);
    wait_done(1'b0, "b2b", nb, da);
    chk("b2b.busy_cycles", 32'(nb), 32'd3);
    chk("b2b.done_cycle", 32'(da), 32'd4);
    check_res(1'b0, "b2b", 16'h0F, 1'b1, 1'b0, 1'b0, 1'b0);

    // reset mid-RUN
    @(negedge clk);
    launch(1'b0, 16'hFF, 16'h01, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rrun.busy", 32'(busy8), 32'd0);
    chk("rrun.done", 32'(done8), 32'd0);
    check_res(1'b0, "rrun", 16'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rrun.done_held", 32'(done8), 32'd0);
    rst_n = 1'b1;
    launch(1'b0, 16'h22, 16'h11, 1'b0);
    wait_done(1'b0, "after_rst", nb, da);
    chk("after_rst.busy_cycles", 32'(nb), 32'd4);
    chk("after_rst.done_cycle", 32'(da), 32'd5);
    check_res(1'b0, "after_rst", 16'h33, 1'b0, 1'b0, 1'b0, 1'b0);

    do_op(1'b1, "w16_add", 16'hFFFF, 16'h0001, 1'b0, 1, 2, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op(1'b1, "w16_sub", 16'h8000, 16'h0001, 1'b1, 1, 2, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_addsub_unit.md
SERIAL_ADDSUB_UNIT -- requirements
Module: serial_addsub_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits, minimum 2.
REQ-002 SHALL have parameter CHUNK, default 2: bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1: single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1: request a new operation; sampled on a rising clk edge.
REQ-006 SHALL have port sub  input  1: 0 = a+b, 1 = a-b; sampled with start.
REQ-007 SHALL have port a  input  WIDTH: first operand; sampled with start.
REQ-008 SHALL have port b  input  WIDTH: second operand; sampled with start.
REQ-009 SHALL have port busy  output  1: high while the operation is in progress (RUN state).
REQ-010 SHALL have port done  output  1: one-cycle pulse; result and flags are valid.
REQ-011 SHALL have port result  output  WIDTH: sum or difference, modulo 2^WIDTH.
REQ-012 SHALL have port cout  output  1: carry out of the MSB; on subtract, 1 = no borrow (a >= b unsigned).
REQ-013 SHALL have port ovf  output  1: two's-complement overflow.
REQ-014 SHALL have port zero  output  1: result == 0.
REQ-015 SHALL have port neg  output  1: result[WIDTH-1].

Function
REQ-016 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-017 SHALL accept start only in IDLE or DONE.
- Acceptance latches a and (b XOR {WIDTH{sub}}) into internal operand registers.
- Acceptance sets the internal carry to sub and the chunk counter to 0.
- Acceptance moves the FSM to RUN.
REQ-018 SHALL ignore start, sub, a and b while in RUN; no effect on the operation in progress.
REQ-019 SHALL, each RUN cycle, add operand chunk[counter] plus the internal carry and store CHUNK sum bits and the new carry; counter then increments.
REQ-020 SHALL, on the edge that processes chunk N-1, enter DONE and load result, cout, ovf, zero and neg together.
- Latency: start accepted at edge t, then done high during the cycle following edge t+N.
- busy is high for exactly N cycles.
REQ-021 SHALL compute ovf as (carry into the MSB) XOR (carry out of the MSB).
REQ-022 SHALL hold done high for exactly one cycle (DONE state).
- Leaving DONE: to IDLE, or directly to RUN if start is high in DONE.
- Back-to-back operations therefore lose no cycle.
REQ-023 SHALL hold result and all flags stable from DONE until the next DONE.
- They SHALL NOT show partial values during RUN.
REQ-024 SHALL drive busy and done from the state register only; neither is ever high at the same time as the other.
REQ-025 SHALL, when CHUNK == WIDTH, complete in one RUN cycle (N = 1) with identical results.
REQ-026 SHALL produce results bit-identical to (a + b) or (a + ~b + 1) at WIDTH+1 bits, for all operand values and both modes.

Reset
REQ-027 SHALL, while rst_n is low, force the FSM to IDLE immediately, independent of clk.
REQ-028 SHALL reset busy, done, result, cout, ovf, zero and neg to 0, and the counter, internal carry and operand registers to 0.
REQ-029 SHALL, on reset during RUN, abandon the operation.
- No done pulse is produced.
- Outputs do not take the partial sum.
REQ-030 SHALL accept start on the first rising edge after rst_n is released.

Verification (WIDTH=8, CHUNK=2 unless stated)
REQ-031 SHALL cover: a=0x7F, b=0x01, sub=0 -> busy for 4 cycles, done on the 5th cycle after start; result=0x80, cout=0, ovf=1, neg=1, zero=0.
REQ-032 SHALL cover: a=0x05, b=0x05, sub=1 -> result=0x00, zero=1, cout=1, ovf=0, neg=0.
REQ-033 SHALL cover subtract overflow and borrow:
- a=0x80, b=0x01, sub=1 -> result=0x7F, cout=1, ovf=1.
- a=0x03, b=0x05, sub=1 -> result=0xFE, cout=0, ovf=0, neg=1.
REQ-034 SHALL cover start pulsed with new operands on cycle 2 of RUN -> ignored; first result unchanged.
- Then start held high in DONE -> second operation begins with no idle cycle.
REQ-035 SHALL cover rst_n low during cycle 2 of RUN (a=0xFF, b=0x01) -> busy=0 and all outputs 0 immediately; no done pulse.
- Next operation computes correctly.
REQ-036 SHALL cover WIDTH=16, CHUNK=16: a=0xFFFF, b=0x0001, sub=0 -> done on the 2nd cycle after start; result=0x0000, cout=1, zero=1, ovf=0.
